// File: rtl/enoc_packet_sink.sv
// ENoC ejection endpoint: small FIFO with throttled drain plus windowed packet/latency statistics.
// Optional per-source sequence check is compiled in with ENOC_SINK_SEQ_CHECK_EN.
module enoc_packet_sink #(
  parameter int NODE_ID = 0,
  parameter int ADDR_W  = 4,
  parameter int SEQ_W   = 8,
  parameter int TS_W    = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int N_NODES = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [2*ADDR_W+SEQ_W+TS_W+DATA_W-1:0]    i_data,
  input  logic                                     i_data_val,
  output logic                                     o_en,
  input  logic                                     i_sink_en,
  input  logic [TS_W-1:0]                          i_time,
  input  logic                                     i_start,
  input  logic                                     i_stop,
  output logic                                     o_active,
  output logic                                     o_done,
  output logic [31:0]                              o_pkt_count,
  output logic [15:0]                              o_misroute,
  output logic [31:0]                              o_lat_sum,
  output logic [TS_W-1:0]                          o_lat_max,
  output logic [15:0]                              o_seq_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int HDR_W = 2*ADDR_W + SEQ_W + TS_W;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_e;

  // Only the header is stored; the payload is consumed at the port.
  logic [HDR_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             empty, full, push, pop;

  logic [HDR_W-1:0]  head;
  logic [ADDR_W-1:0] h_dest, h_src;
  logic [SEQ_W-1:0]  h_seq;
  logic [TS_W-1:0]   h_ts, lat;

  state_e           state_q;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      mis_q, mis_d;
  logic [31:0]      sum_q, sum_d;
  logic [TS_W-1:0]  max_q, max_d;
  logic [32:0]      sum_wide;
  logic             count_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_en  = !full;
  assign push  = i_data_val && o_en;
  assign pop   = !empty && i_sink_en;

  assign head   = mem_q[rd_q[AW-1:0]];
  assign h_dest = head[HDR_W-1 -: ADDR_W];
  assign h_src  = head[HDR_W-ADDR_W-1 -: ADDR_W];
  assign h_seq  = head[TS_W +: SEQ_W];
  assign h_ts   = head[TS_W-1:0];
  assign lat    = i_time - h_ts;

  // A pop in the i_start cycle belongs to no window.
  assign count_pop = pop && (state_q == MEASURE) && !i_start;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= i_data[DATA_W +: HDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    mis_d    = (h_dest != ADDR_W'(NODE_ID) && mis_q != '1) ? mis_q + 16'd1 : mis_q;
    sum_wide = {1'b0, sum_q} + 33'(lat);
    sum_d    = sum_wide[32] ? '1 : sum_wide[31:0];
    max_d    = (lat > max_q) ? lat : max_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mis_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else if (i_start) begin
      state_q <= MEASURE;
      cnt_q   <= '0;
      mis_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      if (count_pop) begin
        cnt_q <= cnt_d;
        mis_q <= mis_d;
        sum_q <= sum_d;
        max_q <= max_d;
      end
      if (state_q == MEASURE && i_stop) state_q <= DONE;
    end
  end

  assign o_active    = (state_q == MEASURE);
  assign o_done      = (state_q == DONE);
  assign o_pkt_count = cnt_q;
  assign o_misroute  = mis_q;
  assign o_lat_sum   = sum_q;
  assign o_lat_max   = max_q;

`ifdef ENOC_SINK_SEQ_CHECK_EN
  logic [SEQ_W-1:0] exp_q [N_NODES];
  logic [15:0]      serr_q;
  logic             src_ok;

  assign src_ok = (32'(h_src) < 32'(N_NODES));

  // The table tracks every pop so it resyncs outside the window too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NODES; i++) exp_q[i] <= '0;
      serr_q <= '0;
    end else begin
      if (pop && src_ok) exp_q[h_src] <= h_seq + 1'b1;
      if (i_start) serr_q <= '0;
      else if (count_pop && src_ok && h_seq != exp_q[h_src] && serr_q != '1)
        serr_q <= serr_q + 16'd1;
    end
  end

  assign o_seq_err = serr_q;

  logic unused_bits;
  assign unused_bits = ^i_data[DATA_W-1:0];
`else
  assign o_seq_err = '0;

  logic unused_bits;
  assign unused_bits = ^{i_data[DATA_W-1:0], h_src, h_seq};
`endif

endmodule

// File: tb/tb_enoc_packet_sink.sv
// Directed bench for enoc_packet_sink: window stats, backpressure, ts wrap, reset, sequence check.
module tb_enoc_packet_sink;

  logic        clk;
  logic        reset_n;
  logic [63:0] i_data;
  logic        i_data_val;
  logic        o_en;
  logic        i_sink_en;
  logic [15:0] i_time;
  logic        i_start;
  logic        i_stop;
  logic        o_active;
  logic        o_done;
  logic [31:0] o_pkt_count;
  logic [15:0] o_misroute;
  logic [31:0] o_lat_sum;
  logic [15:0] o_lat_max;
  logic [15:0] o_seq_err;

  int n_cmp = 0;
  int n_err = 0;

  enoc_packet_sink dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val),
    .o_en(o_en), .i_sink_en(i_sink_en), .i_time(i_time), .i_start(i_start),
    .i_stop(i_stop), .o_active(o_active), .o_done(o_done), .o_pkt_count(o_pkt_count),
    .o_misroute(o_misroute), .o_lat_sum(o_lat_sum), .o_lat_max(o_lat_max),
    .o_seq_err(o_seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [3:0] d, input logic [3:0] s,
                                     input logic [7:0] q, input logic [15:0] t);
    return {d, s, q, t, 16'hA5A5, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one packet with the drain off, then pop it alone at time tp.
  task automatic send_pop(input logic [3:0] d, input logic [3:0] s, input logic [7:0] q,
                          input logic [15:0] ts, input logic [15:0] tp);
    i_data = mk(d, s, q, ts); i_data_val = 1'b1; i_sink_en = 1'b0;
    tick();
    i_data_val = 1'b0; i_sink_en = 1'b1; i_time = tp;
    tick();
    i_sink_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; i_data = '0; i_data_val = 1'b0; i_sink_en = 1'b0;
    i_time = '0; i_start = 1'b0; i_stop = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_en", o_en, 1);
    chk("rst_active", o_active, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cnt", o_pkt_count, 0);
    chk("rst_sum", o_lat_sum, 0);
    chk("rst_max", o_lat_max, 0);
    chk("rst_mis", o_misroute, 0);
    chk("rst_seq", o_seq_err, 0);

    // Basic window: three packets, latency 5 each
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("start_active", o_active, 1);
    i_data_val = 1'b1;
    for (int t = 10; t <= 12; t++) begin
      i_data = mk(4'd0, 4'd1, 8'd0, 16'(t));
      tick();
    end
    i_data_val = 1'b0; i_sink_en = 1'b1;
    for (int t = 15; t <= 17; t++) begin
      i_time = 16'(t);
      tick();
    end
    i_sink_en = 1'b0;
    chk("basic_cnt", o_pkt_count, 3);
    chk("basic_sum", o_lat_sum, 15);
    chk("basic_max", o_lat_max, 5);
    chk("basic_mis", o_misroute, 0);

    // Backpressure: fill to 4, then stream with drain enabled (latency 0)
    i_time = 16'd20; i_data = mk(4'd0, 4'd1, 8'd0, 16'd20); i_data_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_fill_en", o_en, (k < 3) ? 1 : 0);
    end
    tick();
    chk("bp_hold_en", o_en, 0);
    i_sink_en = 1'b1;
    tick();
    chk("bp_first_pop_en", o_en, 1);
    chk("bp_first_pop_cnt", o_pkt_count, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_stream_en", o_en, 1);
    end
    chk("bp_stream_cnt", o_pkt_count, 7);
    i_data_val = 1'b0;
    repeat (3) tick();
    chk("bp_drain_cnt", o_pkt_count, 10);
    tick();
    chk("bp_empty_cnt", o_pkt_count, 10);
    chk("bp_sum", o_lat_sum, 15);
    chk("bp_max", o_lat_max, 5);

    // Minimum latency: push into empty FIFO pops on the following edge
    i_data_val = 1'b1;
    tick();
    chk("minlat_push_cnt", o_pkt_count, 10);
    i_data_val = 1'b0;
    tick();
    chk("minlat_pop_cnt", o_pkt_count, 11);
    i_sink_en = 1'b0;

    // Restart clears; timestamp wrap and misroute
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("restart_cnt", o_pkt_count, 0);
    chk("restart_active", o_active, 1);
    chk("restart_max", o_lat_max, 0);
    send_pop(4'd0, 4'd1, 8'd0, 16'hFFFE, 16'h0003);
    chk("wrap_sum", o_lat_sum, 5);
    chk("wrap_max", o_lat_max, 5);
    chk("wrap_cnt", o_pkt_count, 1);
    send_pop(4'd1, 4'd1, 8'd0, 16'd100, 16'd102);
    chk("misroute", o_misroute, 1);
    chk("mis_cnt", o_pkt_count, 2);
    chk("mis_sum", o_lat_sum, 7);

    // Mid-operation reset with FIFO full in MEASURE
    i_data = mk(4'd0, 4'd1, 8'd0, 16'd0); i_data_val = 1'b1;
    repeat (4) tick();
    i_data_val = 1'b0;
    chk("mr_full_en", o_en, 0);
    reset_n = 1'b0;
    tick();
    chk("mr_en", o_en, 1);
    chk("mr_active", o_active, 0);
    chk("mr_cnt", o_pkt_count, 0);
    chk("mr_mis", o_misroute, 0);
    chk("mr_sum", o_lat_sum, 0);
    chk("mr_max", o_lat_max, 0);
    reset_n = 1'b1;
    tick();
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_sink_en = 1'b1; i_time = 16'd50;
    repeat (2) tick();
    i_sink_en = 1'b0;
    chk("mr_no_stale", o_pkt_count, 0);

    // Window control: pops in IDLE are not counted
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    i_data = mk(4'd0, 4'd1, 8'd0, 16'd50); i_time = 16'd55;
    i_data_val = 1'b1; i_sink_en = 1'b1;
    repeat (2) tick();
    i_data_val = 1'b0;
    tick();
    i_sink_en = 1'b0;
    chk("idle_cnt", o_pkt_count, 0);
    chk("idle_sum", o_lat_sum, 0);
    chk("idle_active", o_active, 0);
    i_start = 1'b1; i_stop = 1'b1; tick(); i_start = 1'b0; i_stop = 1'b0;
    chk("both_active", o_active, 1);
    chk("both_done", o_done, 0);
    send_pop(4'd0, 4'd1, 8'd0, 16'd60, 16'd62);
    chk("win_cnt", o_pkt_count, 1);
    chk("win_sum", o_lat_sum, 2);
    i_data = mk(4'd0, 4'd1, 8'd0, 16'd70); i_data_val = 1'b1;
    tick();
    i_data_val = 1'b0; i_stop = 1'b1; i_sink_en = 1'b1; i_time = 16'd73;
    tick();
    i_stop = 1'b0; i_sink_en = 1'b0;
    chk("stop_cnt", o_pkt_count, 2);
    chk("stop_sum", o_lat_sum, 5);
    chk("stop_done", o_done, 1);
    chk("stop_active", o_active, 0);
    send_pop(4'd1, 4'd1, 8'd0, 16'd80, 16'd90);
    send_pop(4'd1, 4'd1, 8'd0, 16'd80, 16'd90);
    chk("frozen_cnt", o_pkt_count, 2);
    chk("frozen_sum", o_lat_sum, 5);
    chk("frozen_mis", o_misroute, 0);
    chk("frozen_max", o_lat_max, 3);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("done_restart_active", o_active, 1);
    chk("done_restart_done", o_done, 0);
    chk("done_restart_cnt", o_pkt_count, 0);

`ifdef ENOC_SINK_SEQ_CHECK_EN
    send_pop(4'd0, 4'd2, 8'd0, 16'd0, 16'd1);
    send_pop(4'd0, 4'd2, 8'd1, 16'd0, 16'd1);
    send_pop(4'd0, 4'd2, 8'd3, 16'd0, 16'd1);
    send_pop(4'd0, 4'd2, 8'd4, 16'd0, 16'd1);
    chk("seq_gap", o_seq_err, 1);
    send_pop(4'd0, 4'd3, 8'd254, 16'd0, 16'd1);
    chk("seq_resync", o_seq_err, 2);
    send_pop(4'd0, 4'd3, 8'd255, 16'd0, 16'd1);
    send_pop(4'd0, 4'd3, 8'd0, 16'd0, 16'd1);
    chk("seq_wrap", o_seq_err, 2);
`else
    send_pop(4'd0, 4'd2, 8'd7, 16'd0, 16'd1);
    chk("seq_tied", o_seq_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
